// File: rtl/calc_pkg.sv
// Shared types for the two-digit calculator sequencer.
//   - operand/result widths
//   - operator codes understood by the downstream ALU
//   - sequencer states and decoded press events
package calc_pkg;

  localparam int OPERAND_W = 4;
  localparam int RESULT_W  = 7;

  // Code 3 is unused; the operator cycle returns to ADD from it.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RESULT = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  // One winner per cycle after priority encoding of the four switches.
  typedef enum logic [2:0] {
    PR_NONE = 3'd0,
    PR_EQ   = 3'd1,
    PR_OP   = 3'd2,
    PR_A    = 3'd3,
    PR_B    = 3'd4
  } press_e;

  function automatic op_e next_op(input op_e op);
    case (op)
      OP_ADD:  return OP_SUB;
      OP_SUB:  return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_sequencer.sv
// Control FSM for the two-digit switch calculator.
// Sequences operand entry, operator selection and evaluation, runs one
// start/done handshake per evaluation with the ALU, and holds the value and
// error flag shown by the display stage.
// Ports:
//   i_Clk, i_Rst_L                  clock, synchronous active-low reset
//   i_Press_A/B/Op/Eq               single-cycle switch press pulses
//   o_Alu_Start                     single-cycle start strobe
//   o_Alu_A, o_Alu_B, o_Alu_Op      operands/operator, straight from registers
//   i_Alu_Done, i_Alu_Result,
//   i_Alu_Neg                       ALU completion, magnitude, sign
//   o_Disp_Value, o_Disp_Err        display value and error-glyph select
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int c_MAX_OPERAND = 9,
  parameter int c_ALU_TIMEOUT = 64
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Press_A,
  input  logic                 i_Press_B,
  input  logic                 i_Press_Op,
  input  logic                 i_Press_Eq,
  output logic                 o_Alu_Start,
  output logic [OPERAND_W-1:0] o_Alu_A,
  output logic [OPERAND_W-1:0] o_Alu_B,
  output logic [1:0]           o_Alu_Op,
  input  logic                 i_Alu_Done,
  input  logic [RESULT_W-1:0]  i_Alu_Result,
  input  logic                 i_Alu_Neg,
  output logic [RESULT_W-1:0]  o_Disp_Value,
  output logic                 o_Disp_Err
);

  // The counter must be able to hold c_ALU_TIMEOUT itself: the timeout fires
  // in the cycle where it equals c_ALU_TIMEOUT, i.e. c_ALU_TIMEOUT+1 cycles
  // after the start strobe.
  localparam int                CNT_W       = $clog2(c_ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(c_ALU_TIMEOUT);

  function automatic logic [OPERAND_W-1:0] inc_operand(input logic [OPERAND_W-1:0] v);
    return (v == OPERAND_W'(c_MAX_OPERAND)) ? '0 : v + 1'b1;
  endfunction

  state_e                state_q, state_d;
  logic [OPERAND_W-1:0]  a_q, a_d, b_q, b_d;
  op_e                   op_q, op_d;
  logic [RESULT_W-1:0]   disp_q, disp_d;
  logic                  err_q, err_d;
  logic                  start_q, start_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  press_e                press;

  // Only the highest-priority press of a cycle is seen; the rest are dropped.
  always_comb begin
    press = PR_NONE;
    if (i_Press_Eq)      press = PR_EQ;
    else if (i_Press_Op) press = PR_OP;
    else if (i_Press_A)  press = PR_A;
    else if (i_Press_B)  press = PR_B;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    disp_d  = disp_q;
    err_d   = err_q;
    start_d = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      ST_ENTRY: begin
        case (press)
          PR_EQ: begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_EXEC;
          end
          PR_OP: op_d = next_op(op_q);
          PR_A: begin
            a_d    = inc_operand(a_q);
            disp_d = RESULT_W'(inc_operand(a_q));
          end
          PR_B: begin
            b_d    = inc_operand(b_q);
            disp_d = RESULT_W'(inc_operand(b_q));
          end
          default: ;
        endcase
      end

      // Operands are frozen here, so the ALU sees stable inputs until done.
      // A done arriving on the timeout cycle still takes precedence.
      ST_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (i_Alu_Done) begin
          if (i_Alu_Neg) begin
            disp_d  = '0;
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            disp_d  = i_Alu_Result;
            err_d   = 1'b0;
            state_d = ST_RESULT;
          end
        end else if (cnt_q == TIMEOUT_CNT) begin
          disp_d  = '0;
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end

      // A new operand press starts a fresh calculation from 0/0 but keeps op.
      ST_RESULT: begin
        case (press)
          PR_EQ: begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_EXEC;
          end
          PR_OP: begin
            op_d    = next_op(op_q);
            state_d = ST_ENTRY;
          end
          PR_A: begin
            a_d     = inc_operand('0);
            b_d     = '0;
            disp_d  = RESULT_W'(inc_operand('0));
            state_d = ST_ENTRY;
          end
          PR_B: begin
            a_d     = '0;
            b_d     = inc_operand('0);
            disp_d  = RESULT_W'(inc_operand('0));
            state_d = ST_ENTRY;
          end
          default: ;
        endcase
      end

      // Any press only acknowledges the error; it is not applied.
      ST_ERROR: begin
        if (press != PR_NONE) begin
          a_d     = '0;
          b_d     = '0;
          op_d    = OP_ADD;
          disp_d  = '0;
          err_d   = 1'b0;
          state_d = ST_ENTRY;
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q <= ST_ENTRY;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      disp_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Alu_Start  = start_q;
  assign o_Alu_A      = a_q;
  assign o_Alu_B      = b_q;
  assign o_Alu_Op     = op_q;
  assign o_Disp_Value = disp_q;
  assign o_Disp_Err   = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural ALU and a queue of
// expected evaluation outcomes.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int MAX_OP  = 9;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       pa = 1'b0, pb = 1'b0, pop = 1'b0, peq = 1'b0;
  logic       alu_start;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic       alu_done = 1'b0;
  logic [6:0] alu_result = '0;
  logic       alu_neg = 1'b0;
  logic [6:0] disp_value;
  logic       disp_err;

  int errors = 0;
  int checks = 0;
  int alu_lat = 0;   // negative: ALU never answers

  typedef struct {
    int val;
    int err;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_pop;

  int ea, eb, eop, k_to;
  int ma, mb, mop;

  always #5 clk = ~clk;

  calc_sequencer #(.c_MAX_OPERAND(MAX_OP), .c_ALU_TIMEOUT(TIMEOUT)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_Press_A    (pa),
    .i_Press_B    (pb),
    .i_Press_Op   (pop),
    .i_Press_Eq   (peq),
    .o_Alu_Start  (alu_start),
    .o_Alu_A      (alu_a),
    .o_Alu_B      (alu_b),
    .o_Alu_Op     (alu_op),
    .i_Alu_Done   (alu_done),
    .i_Alu_Result (alu_result),
    .i_Alu_Neg    (alu_neg),
    .o_Disp_Value (disp_value),
    .o_Disp_Err   (disp_err)
  );

  // Behavioural ALU: answers alu_lat cycles after the start cycle.
  always begin
    @(posedge clk);
    #1;
    if (alu_start && alu_lat >= 0) begin
      ma = int'(alu_a);
      mb = int'(alu_b);
      mop = int'(alu_op);
      for (int i = 0; i < alu_lat; i++) begin
        @(posedge clk);
        #1;
      end
      alu_neg = 1'b0;
      case (mop)
        1: begin
          if (ma >= mb) alu_result = 7'(ma - mb);
          else begin
            alu_result = 7'(mb - ma);
            alu_neg = 1'b1;
          end
        end
        2:       alu_result = 7'(ma * mb);
        default: alu_result = 7'(ma + mb);
      endcase
      alu_done = 1'b1;
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      alu_neg = 1'b0;
    end
  end

  function automatic int m_inc(input int v);
    return (v == MAX_OP) ? 0 : v + 1;
  endfunction

  function automatic exp_t model_eval(input int a, input int b, input int op);
    exp_t e;
    e.err = 0;
    case (op)
      1: begin
        if (a >= b) e.val = a - b;
        else begin
          e.val = 0;
          e.err = 1;
        end
      end
      2:       e.val = a * b;
      default: e.val = a + b;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called at a negedge; drives the pulse for exactly one rising edge.
  task automatic press(input logic a, input logic b, input logic op, input logic eq);
    pa = a;
    pb = b;
    pop = op;
    peq = eq;
    @(negedge clk);
    pa = 1'b0;
    pb = 1'b0;
    pop = 1'b0;
    peq = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (alu_done) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    e_pop = exp_q.pop_front();
    check({tag, "_value"}, 32'(disp_value), 32'(e_pop.val));
    check({tag, "_err"}, 32'(disp_err), 32'(e_pop.err));
    check({tag, "_start_low"}, 32'(alu_start), 32'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("rst_start", 32'(alu_start), 32'd0);
    check("rst_a", 32'(alu_a), 32'd0);
    check("rst_b", 32'(alu_b), 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    check("rst_disp", 32'(disp_value), 32'd0);
    check("rst_err", 32'(disp_err), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_ENTRY));
    rst_l = 1'b1;
    ea = 0; eb = 0; eop = 0;

    // 2 + 3
    repeat (2) begin press(1, 0, 0, 0); ea = m_inc(ea); end
    check("a_x2", 32'(alu_a), 32'(ea));
    check("disp_a_x2", 32'(disp_value), 32'(ea));
    repeat (3) begin press(0, 1, 0, 0); eb = m_inc(eb); end
    check("b_x3", 32'(alu_b), 32'(eb));
    check("disp_b_x3", 32'(disp_value), 32'(eb));
    press(0, 0, 0, 1);
    exp_q.push_back(model_eval(ea, eb, eop));
    check("add_start", 32'(alu_start), 32'd1);
    wait_result("add");
    check("add_state", 32'(dut.state_q), 32'(ST_RESULT));

    // SUB with negative outcome, then clear the error
    press(0, 0, 1, 0); eop = 1;
    check("op_sub", 32'(alu_op), 32'(eop));
    check("op_disp_hold", 32'(disp_value), 32'(e_pop.val));
    repeat (3) begin press(1, 0, 0, 0); ea = m_inc(ea); end
    repeat (5) begin press(0, 1, 0, 0); eb = m_inc(eb); end
    check("sub_a", 32'(alu_a), 32'(ea));
    check("sub_b", 32'(alu_b), 32'(eb));
    press(0, 0, 0, 1);
    exp_q.push_back(model_eval(ea, eb, eop));
    check("sub_start", 32'(alu_start), 32'd1);
    wait_result("sub_neg");
    press(1, 0, 0, 0); ea = 0; eb = 0; eop = 0;
    check("clr_err", 32'(disp_err), 32'd0);
    check("clr_disp", 32'(disp_value), 32'd0);
    check("clr_a", 32'(alu_a), 32'(ea));
    check("clr_b", 32'(alu_b), 32'(eb));
    check("clr_op", 32'(alu_op), 32'(eop));

    // Operand wrap and operator wrap
    for (int i = 0; i < 10; i++) begin
      press(1, 0, 0, 0);
      ea = m_inc(ea);
      if (i == 8) check("a_at_max", 32'(disp_value), 32'(ea));
    end
    check("a_wrap", 32'(alu_a), 32'(ea));
    check("a_wrap_disp", 32'(disp_value), 32'(ea));
    repeat (3) begin press(0, 0, 1, 0); eop = (eop + 1) % 3; end
    check("op_wrap", 32'(alu_op), 32'(eop));

    // MUL 3 * 4
    repeat (2) begin press(0, 0, 1, 0); eop = (eop + 1) % 3; end
    repeat (3) begin press(1, 0, 0, 0); ea = m_inc(ea); end
    repeat (4) begin press(0, 1, 0, 0); eb = m_inc(eb); end
    press(0, 0, 0, 1);
    exp_q.push_back(model_eval(ea, eb, eop));
    wait_result("mul");

    // ALU never answers: timeout
    alu_lat = -1;
    press(0, 0, 1, 0); eop = (eop + 1) % 3;
    check("op_from_result", 32'(alu_op), 32'(eop));
    check("op_from_result_disp", 32'(disp_value), 32'(e_pop.val));
    press(0, 0, 0, 1);
    exp_q.push_back('{val: 0, err: 1});
    check("to_start", 32'(alu_start), 32'd1);
    @(negedge clk);
    check("to_start_width", 32'(alu_start), 32'd0);
    k_to = 0;
    for (int k = 2; k <= 200; k++) begin
      @(negedge clk);
      if (disp_err) begin
        k_to = k;
        break;
      end
    end
    check("to_latency", 32'(k_to), 32'(TIMEOUT + 1));
    e_pop = exp_q.pop_front();
    check("to_value", 32'(disp_value), 32'(e_pop.val));
    check("to_err", 32'(disp_err), 32'(e_pop.err));
    press(0, 1, 0, 0); ea = 0; eb = 0; eop = 0;
    check("to_clr_b", 32'(alu_b), 32'(eb));
    check("to_clr_err", 32'(disp_err), 32'd0);

    // Same-cycle A+Eq, then presses ignored during EXEC
    alu_lat = 3;
    press(1, 0, 0, 0); ea = m_inc(ea);
    press(1, 0, 0, 1);
    exp_q.push_back(model_eval(ea, eb, eop));
    check("prio_start", 32'(alu_start), 32'd1);
    check("prio_a_kept", 32'(alu_a), 32'(ea));
    press(1, 1, 1, 0);
    check("exec_a_ign", 32'(alu_a), 32'(ea));
    check("exec_b_ign", 32'(alu_b), 32'(eb));
    check("exec_op_ign", 32'(alu_op), 32'(eop));
    wait_result("prio");

    // Reset during EXEC; the late done must be ignored
    alu_lat = 4;
    press(0, 1, 0, 0); ea = 0; eb = 1;
    check("res_b_restart", 32'(alu_b), 32'(eb));
    check("res_a_cleared", 32'(alu_a), 32'(ea));
    press(0, 0, 0, 1);
    check("mid_start", 32'(alu_start), 32'd1);
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_state", 32'(dut.state_q), 32'(ST_ENTRY));
    check("mid_start_low", 32'(alu_start), 32'd0);
    check("mid_a", 32'(alu_a), 32'd0);
    check("mid_b", 32'(alu_b), 32'd0);
    check("mid_op", 32'(alu_op), 32'd0);
    check("mid_disp", 32'(disp_value), 32'd0);
    check("mid_err", 32'(disp_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
